scan_dump_ctrl: RTL

//  Sequences a scan-chain dump of the DUT for the DFT host port: freezes the DUT between ops,

---
 rtl/scan_dump_ctrl.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/scan_dump_ctrl.sv
// -----------------------------------------------------------------------------
// scan_dump_ctrl
//
// Sequences a scan-chain dump of the DUT for the DFT host port. On a host dump
// request the controller blocks new DUT requests, waits for any in-flight DUT
// op to drain, freezes the DUT and rotates the whole scan chain once
// (recirculating, so the chain content is preserved). The serial bits are
// packed into WORD_W-bit words, each presented with a one-cycle strobe, and
// the dump is closed with a commit/commit-ack handshake.
//
// Parameters
//   CHAIN_LEN  scan chain length in bits (nonzero multiple of WORD_W)
//   WORD_W     dump word width
//
// Ports
//   clk             in   system clock, posedge
//   reset           in   asynchronous, active-low reset
//   dft_val_op      in   host dump request (level)
//   dft_op_ack      out  one-cycle pulse, dump request accepted
//   dft_out         out  dump word, valid with dft_out_strobe
//   dft_out_strobe  out  one-cycle pulse per completed word
//   dft_op_commit   out  dump complete, held until dft_commit_ack
//   dft_commit_ack  in   host acknowledges commit
//   scan_en         out  chain shift enable
//   scan_out        in   chain serial output (bit 0 first)
//   scan_in         out  chain serial input (recirculated scan_out)
//   dut_val_op      in   raw host DUT request
//   dut_busy        in   DUT has an op in flight
//   dut_val_gated   out  DUT request after dump blocking
//   dut_freeze      out  DUT functional clock-enable off
// -----------------------------------------------------------------------------
module scan_dump_ctrl #(
    parameter int CHAIN_LEN = 64,
    parameter int WORD_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dft_val_op,
    output logic              dft_op_ack,
    output logic [WORD_W-1:0] dft_out,
    output logic              dft_out_strobe,
    output logic              dft_op_commit,
    input  logic              dft_commit_ack,
    output logic              scan_en,
    input  logic              scan_out,
    output logic              scan_in,
    input  logic              dut_val_op,
    input  logic              dut_busy,
    output logic              dut_val_gated,
    output logic              dut_freeze
);

    localparam int CNT_W = $clog2(CHAIN_LEN + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_DUT = 2'd1,
        SHIFT    = 2'd2,
        COMMIT   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;     // bits shifted in this dump
    logic [CNT_W-1:0]  wcnt_q, wcnt_d;   // bit position inside current word
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [WORD_W-1:0] out_q, out_d;
    logic              ack_q, ack_d;
    logic              full_q, full_d;   // shreg holds a complete word
    logic              last_q, last_d;   // that word is the final one
    logic              strobe_q, strobe_d;
    logic              commit_q, commit_d;
    logic              block;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            wcnt_q   <= '0;
            shreg_q  <= '0;
            out_q    <= '0;
            ack_q    <= 1'b0;
            full_q   <= 1'b0;
            last_q   <= 1'b0;
            strobe_q <= 1'b0;
            commit_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wcnt_q   <= wcnt_d;
            shreg_q  <= shreg_d;
            out_q    <= out_d;
            ack_q    <= ack_d;
            full_q   <= full_d;
            last_q   <= last_d;
            strobe_q <= strobe_d;
            commit_q <= commit_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wcnt_d   = wcnt_q;
        shreg_d  = shreg_q;
        out_d    = out_q;
        ack_d    = 1'b0;
        full_d   = 1'b0;
        last_d   = 1'b0;
        strobe_d = 1'b0;
        commit_d = commit_q;

        // A completed word is published one cycle after it fills the shift
        // register; the final word raises commit in the same cycle.
        if (full_q) begin
            out_d    = shreg_q;
            strobe_d = 1'b1;
            if (last_q) begin
                commit_d = 1'b1;
            end
        end

        unique case (state_q)
            IDLE: begin
                cnt_d  = '0;
                wcnt_d = '0;
                if (dft_val_op) begin
                    ack_d   = 1'b1;
                    state_d = WAIT_DUT;
                end
            end
            WAIT_DUT: begin
                if (!dut_busy) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // Right shift with the new bit at the MSB: after WORD_W bits
                // the first bit of the word sits in bit 0.
                shreg_d             = shreg_q >> 1;
                shreg_d[WORD_W-1]   = scan_out;
                cnt_d               = cnt_q + 1'b1;
                if (wcnt_q == CNT_W'(WORD_W - 1)) begin
                    wcnt_d = '0;
                    full_d = 1'b1;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
                if (cnt_q == CNT_W'(CHAIN_LEN - 1)) begin
                    last_d  = 1'b1;
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                // Ack only counts once commit is actually visible to the host.
                if (commit_q && dft_commit_ack) begin
                    commit_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A dump request in IDLE blocks the DUT in the same cycle so the dump
    // wins a simultaneous DUT request.
    assign block          = (state_q != IDLE) || dft_val_op;
    assign dut_val_gated  = dut_val_op && !block && reset;

    assign scan_en        = (state_q == SHIFT);
    assign scan_in        = scan_en ? scan_out : 1'b0;
    assign dut_freeze     = (state_q == SHIFT) || (state_q == COMMIT);
    assign dft_op_ack     = ack_q;
    assign dft_out        = out_q;
    assign dft_out_strobe = strobe_q;
    assign dft_op_commit  = commit_q;

endmodule
